// File: rtl/relu_maxpool_22.sv
// ReLU + 2x2/stride-2 max pooling over a DxD float32 pixel stream, one half-width line buffer.
// Optional ReLU stage enabled by defining RELU_MAXPOOL_RELU_EN; otherwise a signed IEEE-754 max is used.
module relu_maxpool_22 #(
    parameter int unsigned D          = 299,
    parameter int unsigned data_width = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [data_width-1:0] pxl_in,
    output logic [data_width-1:0] pxl_out,
    output logic                  valid_out,
    output logic                  last_out
);

    localparam int unsigned CW   = (D > 1) ? $clog2(D) : 1;
    localparam int unsigned CW1  = CW + 1;
    localparam int unsigned HALF = D / 2;
    localparam int unsigned LBW  = (HALF > 1) ? $clog2(HALF) : 1;
    // Pooled extent: the trailing row/column of an odd frame lies outside it
    localparam int unsigned LIM  = 2 * HALF;
    localparam int unsigned MSB  = data_width - 1;

    logic [CW-1:0]         col;
    logic [CW-1:0]         row;
    logic [data_width-1:0] pair;
    logic [data_width-1:0] line_buf [HALF];

    logic [data_width-1:0] px;
    logic [data_width-1:0] pair_max;
    logic [data_width-1:0] win_max;
    logic [LBW-1:0]        lb_idx;
    logic                  col_last;
    logic                  row_last;
    logic                  in_win;
    logic                  win_last;

    function automatic logic [data_width-1:0] fmax(
        input logic [data_width-1:0] a,
        input logic [data_width-1:0] b
    );
`ifdef RELU_MAXPOOL_RELU_EN
        return (a > b) ? a : b;
`else
        if (a[MSB] != b[MSB]) begin
            return a[MSB] ? b : a;
        end else if (!a[MSB]) begin
            return (a > b) ? a : b;
        end else begin
            return (a[MSB-1:0] < b[MSB-1:0]) ? a : b;
        end
`endif
    endfunction

    // Pixel conditioning, window comparison and position decode
    always_comb begin
`ifdef RELU_MAXPOOL_RELU_EN
        px = pxl_in[MSB] ? '0 : pxl_in;
`else
        px = pxl_in;
`endif
        lb_idx   = LBW'(col >> 1);
        pair_max = fmax(pair, px);
        win_max  = fmax(pair_max, line_buf[lb_idx]);
        col_last = (col == CW'(D - 1));
        row_last = (row == CW'(D - 1));
        in_win   = ({1'b0, col} < CW1'(LIM)) && ({1'b0, row} < CW1'(LIM));
        win_last = (row == CW'(LIM - 1)) && (col == CW'(LIM - 1));
    end

    // Position counters, pair register and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            col       <= '0;
            row       <= '0;
            pair      <= '0;
            pxl_out   <= '0;
            valid_out <= 1'b0;
            last_out  <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            last_out  <= 1'b0;
            if (valid_in) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + CW'(1);
                end else begin
                    col <= col + CW'(1);
                end
                if (in_win) begin
                    if (!col[0]) begin
                        pair <= px;
                    end else if (row[0]) begin
                        pxl_out   <= win_max;
                        valid_out <= 1'b1;
                        last_out  <= win_last;
                    end
                end
            end
        end
    end

    // Half-width line buffer: even rows write horizontal pair maxima, odd rows read them
    always_ff @(posedge clk) begin
        if (!reset && valid_in && in_win && col[0] && !row[0]) begin
            line_buf[lb_idx] <= pair_max;
        end
    end

endmodule

// File: tb/tb_relu_maxpool_22.sv
// Randomized self-checking bench for relu_maxpool_22 with D=4 and D=5 instances
// checked cycle-by-cycle against a whole-frame reference model.
module tb_relu_maxpool_22;

    logic        clk;
    logic        rst  [2];
    logic        vin  [2];
    logic [31:0] pin  [2];
    logic [31:0] pout [2];
    logic        vout [2];
    logic        lout [2];

    int total = 0;
    int bad   = 0;

    int          dd [2] = '{4, 5};
    int          mr [2];
    int          mc [2];
    logic [31:0] fr [2][5][5];

    relu_maxpool_22 #(.D(4), .data_width(32)) dut4 (
        .clk(clk), .reset(rst[0]), .valid_in(vin[0]), .pxl_in(pin[0]),
        .pxl_out(pout[0]), .valid_out(vout[0]), .last_out(lout[0])
    );

    relu_maxpool_22 #(.D(5), .data_width(32)) dut5 (
        .clk(clk), .reset(rst[1]), .valid_in(vin[1]), .pxl_in(pin[1]),
        .pxl_out(pout[1]), .valid_out(vout[1]), .last_out(lout[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] i2f(input int n);
        int e = 0;
        while ((n >> (e + 1)) != 0) e++;
        return {1'b0, 8'(127 + e), 23'(n << (23 - e))};
    endfunction

    function automatic logic [31:0] cond(input logic [31:0] x);
`ifdef RELU_MAXPOOL_RELU_EN
        return x[31] ? 32'h0 : x;
`else
        return x;
`endif
    endfunction

    // Monotonic key: float ordering becomes plain unsigned ordering
    function automatic logic [31:0] fkey(input logic [31:0] x);
        return x[31] ? ~x : {1'b1, x[30:0]};
    endfunction

    function automatic logic [31:0] fmax2(input logic [31:0] a, input logic [31:0] b);
        return (fkey(a) >= fkey(b)) ? a : b;
    endfunction

    task automatic model_accept(input int u, input logic [31:0] x,
                                output logic ev, output logic [31:0] ep, output logic el);
        int d = dd[u];
        int h = d / 2;
        int r = mr[u];
        int c = mc[u];
        ev = 1'b0; ep = '0; el = 1'b0;
        fr[u][r][c] = cond(x);
        if ((r % 2 == 1) && (c % 2 == 1) && (r < 2 * h) && (c < 2 * h)) begin
            ev = 1'b1;
            ep = fmax2(fmax2(fr[u][r-1][c-1], fr[u][r-1][c]), fmax2(fr[u][r][c-1], fr[u][r][c]));
            el = (r == 2 * h - 1) && (c == 2 * h - 1);
        end
        mc[u] = c + 1;
        if (mc[u] == d) begin
            mc[u] = 0;
            mr[u] = (r + 1 == d) ? 0 : r + 1;
        end
    endtask

    // One clock: drive unit u (other unit idles with junk data), then check both units
    task automatic step(input int u, input logic v, input logic [31:0] x, input logic r);
        logic        ev [2];
        logic        el [2];
        logic [31:0] ep [2];
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b0; vin[i] = 1'b0; pin[i] = $urandom;
            ev[i] = 1'b0; el[i] = 1'b0; ep[i] = '0;
        end
        rst[u] = r; vin[u] = v; pin[u] = x;
        if (r) begin
            mr[u] = 0; mc[u] = 0;
        end else if (v) begin
            model_accept(u, x, ev[u], ep[u], el[u]);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("valid_out[D=%0d]", dd[i]), 32'(vout[i]), 32'(ev[i]));
            check($sformatf("last_out[D=%0d]", dd[i]), 32'(lout[i]), 32'(el[i]));
            if (ev[i] || (r && i == u))
                check($sformatf("pxl_out[D=%0d]", dd[i]), pout[i], ep[i]);
        end
    endtask

    task automatic send_frame(input int u, input int mode, input int npix, input bit gaps);
        logic [31:0] x;
        for (int p = 0; p < npix; p++) begin
            case (mode)
                0:       x = i2f(p + 1);
                1:       x = (p == 5) ? 32'hc000_0000 : 32'hbf80_0000;
                2:       x = 32'h3f80_0000;
                default: begin
                    case ($urandom_range(0, 7))
                        0:       x = 32'h8000_0000;
                        1:       x = 32'h0000_0000;
                        2:       x = 32'h7f80_0000;
                        3:       x = {1'b0, 31'($urandom)};
                        default: x = $urandom;
                    endcase
                end
            endcase
            step(u, 1'b1, x, 1'b0);
            if (gaps) repeat ($urandom_range(0, 3)) step(u, 1'b0, $urandom, 1'b0);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; vin[i] = 1'b1; pin[i] = 32'h4000_0000;
            mr[i] = 0; mc[i] = 0;
        end
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset pxl_out[D=%0d]", dd[i]), pout[i], 32'h0);
            check($sformatf("reset valid_out[D=%0d]", dd[i]), 32'(vout[i]), 32'h0);
            check($sformatf("reset last_out[D=%0d]", dd[i]), 32'(lout[i]), 32'h0);
        end

        send_frame(0, 0, 16, 1'b0);
        send_frame(0, 1, 16, 1'b0);
        send_frame(1, 0, 25, 1'b0);
        send_frame(1, 0, 25, 1'b0);
        send_frame(0, 0, 16, 1'b1);

        send_frame(0, 0, 9, 1'b0);
        step(0, 1'b1, 32'h4100_0000, 1'b1);
        send_frame(0, 0, 16, 1'b0);

        send_frame(1, 2, 25, 1'b0);
        for (int k = 0; k < 6; k++) begin
            send_frame(0, 3, 16, k[0]);
            send_frame(1, 3, 25, ~k[0]);
        end
        send_frame(1, 3, 13, 1'b0);
        step(1, 1'b0, 32'h0, 1'b1);
        send_frame(1, 3, 25, 1'b1);
        repeat (3) step(0, 1'b0, $urandom, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/relu_maxpool_22.md
Name: relu_maxpool_22

Overview:
- Post-processing stage placed directly after conv_11.
- Consumes conv_11's IEEE-754 single-precision pixel stream (pxl_out/valid_out), one pixel per cycle, row-major, channel frames back-to-back.
- Applies ReLU, then 2x2 max pooling with stride 2; a DxD frame becomes floor(D/2) x floor(D/2).
- Uses a single half-width line buffer. No backpressure; the upstream stage cannot stall.

Parameters:
- D, 299: frame width and height in pixels (D >= 2, odd allowed).
- data_width, 32: pixel width, IEEE-754 single precision.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- valid_in  input  1  pxl_in valid this cycle; connects to conv_11 valid_out.
- pxl_in  input  data_width  input pixel, float32; connects to conv_11 pxl_out.
- pxl_out  output  data_width  pooled pixel, float32.
- valid_out  output  1  pxl_out valid, single-cycle pulse per pooled pixel.
- last_out  output  1  high with valid_out on the final pooled pixel of each frame.

Behaviour:
- Reset: on clk edge with reset=1, all outputs go to 0 (pxl_out, valid_out, last_out); col/row counters go to 0; pair register and line-buffer valid state are cleared. Reset takes priority over valid_in.
- Reset mid-frame discards partial windows. The first valid pixel after reset is pixel (0,0) of a new frame.
- Counters:
  - col in 0..D-1, row in 0..D-1; width $clog2(D); both advance only when valid_in=1.
  - col wraps to 0 at D-1 and increments row. row wraps to 0 at D-1 (end of frame).
  - Idle cycles (valid_in=0) change no state and produce no output.
- ReLU (when enabled, see Optional Feature): if pxl_in[31]=1, substitute 0x00000000; this also covers -0. Positive NaN/Inf pass through unchanged.
- Max compare after ReLU: all operands are non-negative, so the max is an unsigned 32-bit compare.
- Even row:
  - Even col: latch the value in the pair register.
  - Odd col: write max(pair, current) to line_buf[col>>1].
- Odd row:
  - Even col: latch the value in the pair register.
  - Odd col: compute max(pair, current, line_buf[col>>1]) and register it to pxl_out; valid_out=1 on the next cycle.
- Latency: valid_out is asserted exactly one cycle after the rising edge on which the window's bottom-right pixel was accepted.
- Odd D: pixels with col=D-1 or row=D-1 are consumed (counters advance) but ignored. No output is produced for them.
- last_out=1 together with valid_out when the output comes from row=2*(D/2)-1 and col=2*(D/2)-1.
- Line buffer:
  - Depth D/2 (integer), width data_width.
  - Written only on even rows, read only on odd rows. No read/write collision on the same entry in one cycle.
  - Implementable as an inferred RAM with registered output or as a register array.
- Frames are contiguous: after the last pixel of a frame, the next valid pixel is (0,0) of the next channel. No gap is required between frames.
- Throughput: one input per cycle sustained; at most one output every 2 cycles.

Optional Feature:
- Macro RELU_MAXPOOL_RELU_EN.
- Defined: ReLU is applied as above and the compare is unsigned.
- Undefined: no ReLU; inputs pass through unchanged and the compare is full IEEE-754 signed max:
  - Signs differ: the positive operand wins.
  - Both positive: the larger magnitude wins.
  - Both negative: the smaller magnitude wins.
  - +0 vs -0: +0 wins.
  - NaN is treated as its raw bit pattern under these rules (no special handling).

Test Plan:
- D=4, RELU_EN defined, frame values 1.0..16.0 row-major (0x3f800000..0x41800000) with valid_in held high:
  - Outputs in order: 0x40c00000 (6.0), 0x41000000 (8.0), 0x41600000 (14.0), 0x41800000 (16.0).
  - Each output appears 1 cycle after accepting pixels 6, 8, 14 and 16 respectively.
  - last_out=1 only on 16.0.
- D=4, all pixels -1.0 (0xbf800000) except one -2.0:
  - RELU_EN defined: 4 outputs, each 0x00000000.
  - RELU_EN undefined: 4 outputs, each 0xbf800000.
- D=5, values 1.0..25.0:
  - Exactly 4 outputs: 7.0, 9.0, 17.0, 19.0; last_out on 19.0.
  - Row 4 and col 4 produce nothing.
  - A second frame sent immediately afterwards yields the same 4 outputs.
- D=4 frame from the first scenario with random 0-3 idle cycles inserted between valid pixels: identical output values and count. valid_out never asserts during an idle stretch except exactly 1 cycle after a window-completing pixel.
- Reset asserted for 1 cycle after 9 pixels of a D=4 frame, then a full 1.0..16.0 frame: no outputs from the aborted frame, then exactly the 4 values from the first scenario. pxl_out, valid_out and last_out read 0 in the cycle after reset.
- D=299, three back-to-back channel frames of constant 1.0 (0x3f800000): exactly 3*149*149 = 66603 outputs, all 0x3f800000, with exactly 3 last_out pulses.
